conv_layer_mem_resp: RTL and testbench

//  Responder side of the CONV layer-memory interface (cwr/caddr_wr/cdata_wr, crd/caddr_rd/cdata_rd, csel).

---
 rtl/conv_layer_mem_resp.sv | 158 +++++++++++++++
 tb/tb_conv_layer_mem_resp.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_mem_resp.sv
// CONV layer-memory responder: L0 (64x64) and L1 (32x32) banks on the cwr/crd/csel port, plus a run
// sequencer that streams L1 to the host. Define CONV_MEM_CHECKSUM_EN to add a 32-bit dump checksum output.
module conv_layer_mem_resp #(
   parameter int DW       = 20,
   parameter int AW       = 12,
   parameter int L0_DEPTH = 4096,
   parameter int L1_DEPTH = 1024
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          ready,
   input  logic          busy,
   input  logic          cwr,
   input  logic [AW-1:0] caddr_wr,
   input  logic [DW-1:0] cdata_wr,
   input  logic          crd,
   input  logic [AW-1:0] caddr_rd,
   output logic [DW-1:0] cdata_rd,
   input  logic [2:0]    csel,
   output logic [DW-1:0] dout,
   output logic          dout_valid,
   input  logic          dout_ready,
   output logic          dout_last,
   output logic          done,
`ifdef CONV_MEM_CHECKSUM_EN
   output logic [31:0]   checksum,
`endif
   output logic          err
);

   localparam int L0_AW = $clog2(L0_DEPTH);
   localparam int L1_AW = $clog2(L1_DEPTH);

   localparam logic [2:0]       SEL_L0   = 3'd1;
   localparam logic [2:0]       SEL_L1   = 3'd3;
   localparam logic [31:0]      L0_LIM   = L0_DEPTH;
   localparam logic [31:0]      L1_LIM   = L1_DEPTH;
   localparam logic [L1_AW-1:0] IDX_LAST = L1_AW'(L1_DEPTH - 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_RUN   = 3'd2;
   localparam logic [2:0] S_DUMP  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [DW-1:0] l0_mem [L0_DEPTH];
   logic [DW-1:0] l1_mem [L1_DEPTH];

   logic [2:0]       state;
   logic             seen_busy;
   logic [L1_AW-1:0] dump_idx;
   logic [L1_AW-1:0] idx_next;
   logic [31:0]      wr_addr_ext;
   logic [31:0]      rd_addr_ext;
   logic             wr_l0_ok;
   logic             wr_l1_ok;
   logic             rd_l0_ok;
   logic             rd_l1_ok;
   logic             illegal_acc;
   logic             dump_hs;

   assign wr_addr_ext = 32'(caddr_wr);
   assign rd_addr_ext = 32'(caddr_rd);

   assign wr_l0_ok = (csel == SEL_L0) && (wr_addr_ext < L0_LIM);
   assign wr_l1_ok = (csel == SEL_L1) && (wr_addr_ext < L1_LIM);
   assign rd_l0_ok = (csel == SEL_L0) && (rd_addr_ext < L0_LIM);
   assign rd_l1_ok = (csel == SEL_L1) && (rd_addr_ext < L1_LIM);

   assign illegal_acc = (cwr && !(wr_l0_ok || wr_l1_ok)) || (crd && !(rd_l0_ok || rd_l1_ok));

   assign ready    = (state == S_START);
   assign done     = (state == S_DONE);
   assign idx_next = dump_idx + 1'b1;
   assign dump_hs  = (state == S_DUMP) && dout_valid && dout_ready;

   // NOTE: memory arrays have no reset; clearing them would forbid RAM inference and they must survive reset anyway.
   always_ff @(posedge clk) begin
      if (cwr && wr_l0_ok) l0_mem[caddr_wr[L0_AW-1:0]] <= cdata_wr;
      if (cwr && wr_l1_ok) l1_mem[caddr_wr[L1_AW-1:0]] <= cdata_wr;
   end

   // NOTE: non-blocking assignment makes a same-edge read of a written address return the old word.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cdata_rd <= '0;
      end else if (crd) begin
         if (rd_l0_ok)      cdata_rd <= l0_mem[caddr_rd[L0_AW-1:0]];
         else if (rd_l1_ok) cdata_rd <= l1_mem[caddr_rd[L1_AW-1:0]];
         else               cdata_rd <= '0;
      end
   end

   // An illegal access in the START cycle still wins over the clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                 err <= 1'b0;
      else if (illegal_acc)      err <= 1'b1;
      else if (state == S_START) err <= 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_IDLE;
         seen_busy  <= 1'b0;
         dump_idx   <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         dout_last  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) state <= S_START;
            S_START: begin
               seen_busy <= 1'b0;
               state     <= S_RUN;
            end
            S_RUN: begin
               if (busy) begin
                  seen_busy <= 1'b1;
               end else if (seen_busy) begin
                  dump_idx   <= '0;
                  dout_valid <= 1'b0;
                  state      <= S_DUMP;
               end
            end
            S_DUMP: begin
               // First cycle fetches word 0; afterwards each handshake prefetches the following word.
               if (!dout_valid) begin
                  dout       <= l1_mem[dump_idx];
                  dout_valid <= 1'b1;
                  dout_last  <= (dump_idx == IDX_LAST);
               end else if (dout_ready) begin
                  if (dout_last) begin
                     dout_valid <= 1'b0;
                     dout_last  <= 1'b0;
                     state      <= S_DONE;
                  end else begin
                     dump_idx  <= idx_next;
                     dout      <= l1_mem[idx_next];
                     dout_last <= (idx_next == IDX_LAST);
                  end
               end
            end
            S_DONE: if (start) state <= S_START;
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef CONV_MEM_CHECKSUM_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                 checksum <= '0;
      else if (state == S_START) checksum <= '0;
      else if (dump_hs)          checksum <= checksum + 32'(dout);
   end
`endif

endmodule

// File: tb/tb_conv_layer_mem_resp.sv
// Bench for conv_layer_mem_resp: CONV-port vector table, randomized traffic against a bank model,
// and full-run dump sequences (steady, stalled, reset mid-dump). Honours CONV_MEM_CHECKSUM_EN.
module tb_conv_layer_mem_resp;

   localparam int DW       = 20;
   localparam int AW       = 12;
   localparam int L0_DEPTH = 4096;
   localparam int L1_DEPTH = 1024;
   localparam int NV       = 19;

   typedef struct {
      logic          cwr;
      logic          crd;
      logic [2:0]    csel;
      logic [AW-1:0] aw;
      logic [DW-1:0] dw;
      logic [AW-1:0] ar;
      logic [DW-1:0] exp_rd;
      logic          exp_err;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset, start, busy, cwr, crd, dout_ready;
   logic [AW-1:0] caddr_wr, caddr_rd;
   logic [DW-1:0] cdata_wr;
   logic [2:0]    csel;
   logic          ready, dout_valid, dout_last, done, err;
   logic [DW-1:0] cdata_rd, dout;
`ifdef CONV_MEM_CHECKSUM_EN
   logic [31:0]   checksum;
`endif

   int n_checks = 0;
   int n_errors = 0;

   logic [DW-1:0] ref_l0 [L0_DEPTH];
   logic [DW-1:0] ref_l1 [L1_DEPTH];
   logic [DW-1:0] ref_cdata;
   logic          ref_err;

   vec_t          vecs [NV];
   logic [DW-1:0] got_q[$];
   bit            last_q[$];
   int            stall_bad;
   bit            dump_timed_out;

   conv_layer_mem_resp #(.DW(DW), .AW(AW), .L0_DEPTH(L0_DEPTH), .L1_DEPTH(L1_DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .ready      (ready),
      .busy       (busy),
      .cwr        (cwr),
      .caddr_wr   (caddr_wr),
      .cdata_wr   (cdata_wr),
      .crd        (crd),
      .caddr_rd   (caddr_rd),
      .cdata_rd   (cdata_rd),
      .csel       (csel),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready),
      .dout_last  (dout_last),
      .done       (done),
`ifdef CONV_MEM_CHECKSUM_EN
      .checksum   (checksum),
`endif
      .err        (err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Model: a legal read returns the pre-edge contents, an illegal read returns 0, an illegal access sets err.
   task automatic do_op(input logic w, input logic r, input logic [2:0] s,
                        input logic [AW-1:0] aw, input logic [DW-1:0] dw, input logic [AW-1:0] ar);
      int  awi, ari;
      bit  wr_ok, rd_ok;
      cwr = w; crd = r; csel = s; caddr_wr = aw; cdata_wr = dw; caddr_rd = ar;
      tick();
      awi   = int'(aw);
      ari   = int'(ar);
      wr_ok = (s == 3'd1 && awi < L0_DEPTH) || (s == 3'd3 && awi < L1_DEPTH);
      rd_ok = (s == 3'd1 && ari < L0_DEPTH) || (s == 3'd3 && ari < L1_DEPTH);
      if (r) ref_cdata = !rd_ok ? '0 : (s == 3'd1 ? ref_l0[ari] : ref_l1[ari]);
      if ((w && !wr_ok) || (r && !rd_ok)) ref_err = 1'b1;
      if (w && wr_ok) begin
         if (s == 3'd1) ref_l0[awi] = dw;
         else           ref_l1[awi] = dw;
      end
      cwr = 1'b0; crd = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_ready"},      32'(ready),      32'd0);
      check({tag, "_cdata_rd"},   32'(cdata_rd),   32'd0);
      check({tag, "_dout"},       32'(dout),       32'd0);
      check({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
      check({tag, "_dout_last"},  32'(dout_last),  32'd0);
      check({tag, "_done"},       32'(done),       32'd0);
      check({tag, "_err"},        32'(err),        32'd0);
`ifdef CONV_MEM_CHECKSUM_EN
      check({tag, "_checksum"},   checksum,        32'd0);
`endif
   endtask

   task automatic start_run(input string tag);
      start = 1'b1;
      tick();
      start = 1'b0;
      check({tag, "_ready_pulse"}, 32'(ready), 32'd1);
      check({tag, "_done_low"},    32'(done),  32'd0);
      tick();
      ref_err = 1'b0;
      check({tag, "_ready_one_cycle"}, 32'(ready), 32'd0);
      check({tag, "_err_cleared"},     32'(err),   32'(ref_err));
   endtask

   task automatic busy_phase(input string tag, input int n);
      busy = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (i == n / 2) start = 1'b1;
         tick();
         start = 1'b0;
      end
      check({tag, "_start_ignored_in_run"}, 32'(ready),      32'd0);
      check({tag, "_no_dump_while_busy"},   32'(dout_valid), 32'd0);
      busy = 1'b0;
   endtask

   task automatic dump_collect(input bit rand_rdy, input int stop_after);
      logic [DW-1:0] prev_dout;
      bit            prev_last, prev_stall, rdy;
      int            cyc;
      got_q.delete();
      last_q.delete();
      stall_bad  = 0;
      prev_stall = 1'b0;
      prev_dout  = '0;
      prev_last  = 1'b0;
      cyc        = 0;
      while (!done && got_q.size() < stop_after && cyc < 5000) begin
         if (prev_stall && (!dout_valid || dout !== prev_dout || dout_last !== prev_last)) stall_bad++;
         rdy        = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         dout_ready = rdy;
         if (dout_valid && rdy) begin
            got_q.push_back(dout);
            last_q.push_back(dout_last);
         end
         prev_stall = dout_valid && !rdy;
         prev_dout  = dout;
         prev_last  = dout_last;
         tick();
         cyc++;
      end
      dout_ready     = 1'b0;
      dump_timed_out = !done && got_q.size() < stop_after;
   endtask

   task automatic verify_dump(input string tag, input int n_exp);
      check({tag, "_timeout"},    32'(dump_timed_out), 32'd0);
      check({tag, "_word_count"}, 32'(got_q.size()),   32'(n_exp));
      check({tag, "_stall_hold"}, 32'(stall_bad),      32'd0);
      for (int i = 0; i < got_q.size() && i < L1_DEPTH; i++) begin
         check($sformatf("%s_word%0d", tag, i), 32'(got_q[i]),  32'(ref_l1[i]));
         check($sformatf("%s_last%0d", tag, i), 32'(last_q[i]), 32'(i == L1_DEPTH - 1));
      end
   endtask

   task automatic check_done(input string tag);
      check({tag, "_done"},       32'(done),       32'd1);
      check({tag, "_valid_off"},  32'(dout_valid), 32'd0);
      check({tag, "_last_off"},   32'(dout_last),  32'd0);
`ifdef CONV_MEM_CHECKSUM_EN
      begin
         logic [31:0] sum;
         sum = '0;
         for (int i = 0; i < L1_DEPTH; i++) sum += 32'(ref_l1[i]);
         check({tag, "_checksum"}, checksum, sum);
      end
`endif
      tick();
      tick();
      check({tag, "_done_held"}, 32'(done), 32'd1);
   endtask

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 3'd1, 12'd5,    20'h12345, 12'd0,    20'h00000, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 3'd1, 12'd0,    20'h00000, 12'd5,    20'h12345, 1'b0};
      vecs[2]  = '{1'b1, 1'b0, 3'd3, 12'd7,    20'h00011, 12'd0,    20'h12345, 1'b0};
      vecs[3]  = '{1'b1, 1'b1, 3'd3, 12'd7,    20'h00AAA, 12'd7,    20'h00011, 1'b0};
      vecs[4]  = '{1'b0, 1'b1, 3'd3, 12'd0,    20'h00000, 12'd7,    20'h00AAA, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 3'd3, 12'd0,    20'h00F0F, 12'd0,    20'h00AAA, 1'b0};
      vecs[6]  = '{1'b0, 1'b0, 3'd3, 12'd0,    20'h00000, 12'd0,    20'h00AAA, 1'b0};
      vecs[7]  = '{1'b1, 1'b0, 3'd2, 12'd7,    20'h55555, 12'd0,    20'h00AAA, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 3'd3, 12'd0,    20'h00000, 12'd1024, 20'h00000, 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 3'd3, 12'd0,    20'h00000, 12'd7,    20'h00AAA, 1'b1};
      vecs[10] = '{1'b1, 1'b0, 3'd3, 12'd1024, 20'h77777, 12'd0,    20'h00AAA, 1'b1};
      vecs[11] = '{1'b0, 1'b1, 3'd3, 12'd0,    20'h00000, 12'd0,    20'h00F0F, 1'b1};
      vecs[12] = '{1'b1, 1'b0, 3'd1, 12'd4095, 20'hFFFFF, 12'd0,    20'h00F0F, 1'b1};
      vecs[13] = '{1'b0, 1'b1, 3'd1, 12'd0,    20'h00000, 12'd4095, 20'hFFFFF, 1'b1};
      vecs[14] = '{1'b0, 1'b1, 3'd0, 12'd0,    20'h00000, 12'd5,    20'h00000, 1'b1};
      vecs[15] = '{1'b1, 1'b0, 3'd1, 12'd7,    20'h0BEEF, 12'd0,    20'h00000, 1'b1};
      vecs[16] = '{1'b0, 1'b1, 3'd3, 12'd0,    20'h00000, 12'd7,    20'h00AAA, 1'b1};
      vecs[17] = '{1'b0, 1'b1, 3'd1, 12'd0,    20'h00000, 12'd7,    20'h0BEEF, 1'b1};
      vecs[18] = '{1'b0, 1'b1, 3'd1, 12'd0,    20'h00000, 12'd5,    20'h12345, 1'b1};

      reset = 1'b1; start = 1'b0; busy = 1'b0; cwr = 1'b0; crd = 1'b0; dout_ready = 1'b0;
      csel = 3'd0; caddr_wr = '0; caddr_rd = '0; cdata_wr = '0;
      ref_cdata = '0;
      ref_err   = 1'b0;
      repeat (3) tick();
      check_reset_outputs("por");
      reset = 1'b0;
      tick();

      // CONV port vectors: basic access, read-before-write, illegal accesses, bank separation
      for (int i = 0; i < NV; i++) begin
         do_op(vecs[i].cwr, vecs[i].crd, vecs[i].csel, vecs[i].aw, vecs[i].dw, vecs[i].ar);
         check($sformatf("vec%0d_cdata_rd", i), 32'(cdata_rd), 32'(vecs[i].exp_rd));
         check($sformatf("vec%0d_err", i),      32'(err),      32'(vecs[i].exp_err));
      end

      // Full run with L1[i]=i and dout_ready tied high
      for (int i = 0; i < L1_DEPTH; i++) do_op(1'b1, 1'b0, 3'd3, AW'(i), DW'(i), '0);
      check("err_sticky_before_start", 32'(err), 32'd1);
      start_run("run1");
      repeat (5) tick();
      check("run1_idle_without_busy", 32'(dout_valid), 32'd0);
      busy_phase("run1", 100);
      dump_collect(1'b0, L1_DEPTH);
      verify_dump("run1", L1_DEPTH);
      check_done("run1");

      // Randomized CONV traffic in DONE, checked against the bank model
      for (int i = 0; i < 64; i++) do_op(1'b1, 1'b0, 3'd1, AW'(i), DW'($urandom), '0);
      for (int i = 0; i < 400; i++) begin
         logic [2:0]    s;
         logic [AW-1:0] aw, ar;
         int            pick;
         pick = int'($urandom_range(0, 9));
         if (pick == 0)     s = 3'($urandom_range(0, 7));
         else if (pick < 4) s = 3'd1;
         else               s = 3'd3;
         aw = (s == 3'd3) ? AW'($urandom_range(0, 1099)) : AW'($urandom_range(0, 63));
         ar = (s == 3'd3) ? AW'($urandom_range(0, 1099)) : AW'($urandom_range(0, 63));
         do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), s, aw, DW'($urandom), ar);
         check($sformatf("rand%0d_cdata_rd", i), 32'(cdata_rd), 32'(ref_cdata));
         check($sformatf("rand%0d_err", i),      32'(err),      32'(ref_err));
      end

      // Dump with random back-pressure over the randomized contents
      start_run("run2");
      busy_phase("run2", 20);
      dump_collect(1'b1, L1_DEPTH);
      verify_dump("run2", L1_DEPTH);
      check_done("run2");

      // Reset in the middle of a dump, then a complete re-dump from index 0
      start_run("run3");
      busy_phase("run3", 10);
      dump_collect(1'b0, 300);
      verify_dump("run3_partial", 300);
      check("run3_idx300_valid", 32'(dout_valid), 32'd1);
      check("run3_idx300_word",  32'(dout),       32'(ref_l1[300]));
      #2;
      reset = 1'b1;
      #1;
      ref_cdata = '0;
      ref_err   = 1'b0;
      check_reset_outputs("midrun_reset");
      tick();
      reset = 1'b0;
      tick();
      check("after_reset_idle", 32'(dout_valid), 32'd0);
      start_run("run4");
      busy_phase("run4", 10);
      dump_collect(1'b0, L1_DEPTH);
      verify_dump("run4", L1_DEPTH);
      check_done("run4");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
